// File: rtl/mem_pkg.sv
// Shared definitions for the load/store adapter: access-size encodings,
// controller states and lane-position helpers.
package mem_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam logic [1:0] MEM_X = 2'b11;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Bit offset of the addressed lane inside the 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == MEM_H) begin
      lane_shift = {addr_lo[1], 4'b0000};
    end else begin
      lane_shift = {addr_lo, 3'b000};
    end
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Lane formatting: extracts and extends load data from a RAM word, and merges
// sub-word store data into a RAM word leaving the other lanes untouched.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shift_s;
  logic [31:0] shifted_s;

  // Lane extract/extend for loads and lane merge for stores.
  always_comb begin
    shift_s   = lane_shift(size, addr_lo);
    shifted_s = word >> shift_s;
    load_data = 32'h0000_0000;
    merged    = word;
    case (size)
      MEM_B: begin
        load_data = {{24{~is_unsigned & shifted_s[7]}}, shifted_s[7:0]};
        merged    = (word & ~(BYTE_MASK << shift_s)) | ((wdata & BYTE_MASK) << shift_s);
      end
      MEM_H: begin
        load_data = {{16{~is_unsigned & shifted_s[15]}}, shifted_s[15:0]};
        merged    = (word & ~(HALF_MASK << shift_s)) | ((wdata & HALF_MASK) << shift_s);
      end
      MEM_W: begin
        load_data = word;
        merged    = wdata;
      end
      default: begin
        load_data = 32'h0000_0000;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store adapter between the core memory stage and a word-only synchronous
// RAM; sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ram_enable,
  output logic        ram_write,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [31:0] RAM_LIMIT = 32'(RAM_SIZE);

  state_t      state_r, state_next_s;
  logic [31:0] addr_r, wdata_r, merge_r, rsp_rdata_r;
  logic        write_r, unsigned_r, rsp_valid_r, rsp_err_r;
  logic [1:0]  size_r;
  logic        accept_s, req_err_s;
  logic [31:0] load_data_s, merged_s;

  assign accept_s  = (state_r == ST_IDLE) & req_valid;
  assign req_err_s = (req_size == MEM_X)
                   | ((req_size == MEM_H) & req_addr[0])
                   | ((req_size == MEM_W) & (req_addr[1:0] != 2'b00))
                   | (req_addr >= RAM_LIMIT);

  mem_lane_fmt u_fmt (
    .word        (ram_rdata),
    .addr_lo     (addr_r[1:0]),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .wdata       (wdata_r),
    .load_data   (load_data_s),
    .merged      (merged_s)
  );

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!req_valid) begin
          state_next_s = ST_IDLE;
        end else if (req_err_s) begin
          state_next_s = ST_RESP;
        end else if (req_write && (req_size == MEM_W)) begin
          state_next_s = ST_WR;
        end else begin
          state_next_s = ST_RD;
        end
      end
      ST_RD:      state_next_s = ST_RD_WAIT;
      ST_RD_WAIT: state_next_s = write_r ? ST_WR : ST_RESP;
      ST_WR:      state_next_s = ST_RESP;
      ST_RESP:    state_next_s = rsp_ready ? ST_IDLE : ST_RESP;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // RAM port decode from the current state and the latched request.
  always_comb begin
    ram_enable = 1'b0;
    ram_write  = 1'b0;
    ram_addr   = 32'h0000_0000;
    ram_wdata  = 32'h0000_0000;
    case (state_r)
      ST_RD: begin
        ram_enable = 1'b1;
        ram_addr   = {addr_r[31:2], 2'b00};
      end
      ST_WR: begin
        ram_enable = 1'b1;
        ram_write  = 1'b1;
        ram_addr   = {addr_r[31:2], 2'b00};
        ram_wdata  = merge_r;
      end
      default: begin
        ram_enable = 1'b0;
      end
    endcase
  end

  // State, request latches, merge buffer and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      merge_r     <= 32'h0000_0000;
      write_r     <= 1'b0;
      size_r      <= MEM_B;
      unsigned_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_next_s;
      rsp_valid_r <= (state_next_s == ST_RESP);
      if (accept_s) begin
        addr_r      <= req_addr;
        wdata_r     <= req_wdata;
        merge_r     <= req_wdata;
        write_r     <= req_write;
        size_r      <= req_size;
        unsigned_r  <= req_unsigned;
        rsp_err_r   <= req_err_s;
        rsp_rdata_r <= 32'h0000_0000;
      end else if (state_r == ST_RD_WAIT) begin
        if (write_r) begin
          merge_r <= merged_s;
        end else begin
          rsp_rdata_r <= load_data_s;
        end
      end
    end
  end

  assign req_ready = (state_r == ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: randomized and directed requests against a byte-level
// reference memory model, with a word RAM model attached to the DUT.
module tb_mem_access_unit;

  localparam int RAM_SIZE = 32768;
  localparam int NWORDS   = RAM_SIZE / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_ready, rsp_valid, rsp_err, ram_enable, ram_write;
  logic [31:0] rsp_rdata, ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  logic [31:0] ram [0:NWORDS-1];
  logic [7:0]  ref_mem [0:RAM_SIZE-1];

  int n_checks = 0;
  int n_pass = 0;

  mem_access_unit #(.RAM_SIZE(RAM_SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_enable(ram_enable), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Word-only synchronous RAM, one-cycle read latency, never reset.
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_write) ram[ram_addr[14:2]] <= ram_wdata;
      else           ram_rdata <= ram[ram_addr[14:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  // Reference behaviour: byte memory, response and expected RAM traffic.
  task automatic model(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                       input logic [1:0] size, input logic uns,
                       output logic err, output logic [31:0] rdata,
                       output int lat, output int nrd, output int nwr);
    int nb;
    logic [31:0] v;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr >= RAM_SIZE);
    rdata = 32'h0;
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
      return;
    end
    nb = 1 << size;
    if (wr) begin
      for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      if (size == 2'd2) begin lat = 2; nrd = 0; nwr = 1; end
      else              begin lat = 4; nrd = 1; nwr = 1; end
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
      if (!uns && size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      rdata = v; lat = 3; nrd = 1; nwr = 0;
    end
  endtask

  // One transaction: drive, watch RAM traffic, check response, hold, release.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                        input logic [1:0] size, input logic uns, input int hold,
                        output logic [31:0] got);
    logic e_err; logic [31:0] e_rdata; int e_lat, e_rd, e_wr;
    int rd, wrc, lat; logic seen; logic [31:0] held;
    model(addr, wdata, wr, size, uns, e_err, e_rdata, e_lat, e_rd, e_wr);
    req_addr = addr; req_wdata = wdata; req_write = wr; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    rd = 0; wrc = 0; lat = 0; seen = 1'b0; got = 32'h0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (ram_enable) begin
        check("ram_addr_align", 32'(ram_addr[1:0]), 32'd0);
        if (ram_write) wrc++; else rd++;
      end
      if (rsp_valid) begin seen = 1'b1; lat = c; end
    end
    if (!seen) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    check("rsp_latency", 32'(lat), 32'(e_lat));
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_rdata", rsp_rdata, e_rdata);
    check("ram_reads", 32'(rd), 32'(e_rd));
    check("ram_writes", 32'(wrc), 32'(e_wr));
    got = rsp_rdata;
    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, held);
      check("hold_err", 32'(rsp_err), 32'(e_err));
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_no_ram", 32'(ram_enable), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got, w;
    logic [31:0] a, wd;
    logic [1:0] sz;
    int r, bad, nwrites;
    for (int i = 0; i < NWORDS; i++) begin
      w = $urandom;
      ram[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_ram_enable", 32'(ram_enable), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);

    do_req(32'h100, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 0, got);
    do_req(32'h100, 32'h0, 1'b0, 2'd2, 1'b0, 0, got);
    check("lw_deadbeef", got, 32'hDEAD_BEEF);

    do_req(32'h20, 32'h80FF_7F01, 1'b1, 2'd2, 1'b0, 0, got);
    do_req(32'h23, 32'h0, 1'b0, 2'd0, 1'b0, 0, got);
    check("lb_23", got, 32'hFFFF_FF80);
    do_req(32'h23, 32'h0, 1'b0, 2'd0, 1'b1, 0, got);
    check("lbu_23", got, 32'h0000_0080);
    do_req(32'h22, 32'h0, 1'b0, 2'd1, 1'b0, 0, got);
    check("lh_22", got, 32'hFFFF_80FF);
    do_req(32'h20, 32'h0, 1'b0, 2'd1, 1'b1, 0, got);
    check("lhu_20", got, 32'h0000_7F01);

    do_req(32'h40, 32'h1122_3344, 1'b1, 2'd2, 1'b0, 0, got);
    do_req(32'h41, 32'hFFFF_FFAA, 1'b1, 2'd0, 1'b0, 0, got);
    check("sb_merge_ram", ram[32'h40 >> 2], 32'h1122_AA44);
    do_req(32'h42, 32'h1234_BEEF, 1'b1, 2'd1, 1'b0, 0, got);
    check("sh_merge_ram", ram[32'h40 >> 2], 32'hBEEF_AA44);

    do_req(32'h102, 32'h0, 1'b0, 2'd2, 1'b0, 0, got);
    check("err_lw_misaligned", got, 32'h0);
    do_req(32'h101, 32'h5555, 1'b1, 2'd1, 1'b0, 0, got);
    do_req(32'h104, 32'h0, 1'b0, 2'd3, 1'b0, 0, got);
    do_req(32'(RAM_SIZE), 32'h0, 1'b0, 2'd2, 1'b0, 0, got);
    check("err_lw_range", got, 32'h0);

    do_req(32'h100, 32'h0, 1'b0, 2'd2, 1'b0, 5, got);
    check("hold_lw_value", got, 32'hDEAD_BEEF);

    // Reset dropped during the read-wait cycle of a byte store.
    w = ram[32'h80 >> 2];
    req_addr = 32'h81; req_wdata = 32'h5A; req_write = 1'b1; req_size = 2'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nwrites = 0;
    @(negedge clk);
    if (ram_enable && ram_write) nwrites++;
    @(negedge clk);
    if (ram_enable && ram_write) nwrites++;
    rst_n = 1'b0;
    @(negedge clk);
    if (ram_enable && ram_write) nwrites++;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ram_enable && ram_write) nwrites++;
    end
    check("rst_no_write", 32'(nwrites), 32'd0);
    check("rst_ram_kept", ram[32'h80 >> 2], w);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_idle", 32'(rsp_valid), 32'd0);

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 99);
      sz = ($urandom_range(0, 99) < 8) ? 2'd3 : 2'($urandom_range(0, 2));
      if (r < 5) a = 32'(RAM_SIZE) + 32'($urandom_range(0, 255)) * 32'd4;
      else if (r < 75) a = 32'($urandom_range(0, RAM_SIZE - 1)) & ~((32'd1 << sz) - 32'd1);
      else a = 32'($urandom_range(0, RAM_SIZE - 1));
      if (r >= 5 && r < 50) a = a & 32'h0000_00FF;
      wd = $urandom;
      do_req(a, wd, 1'($urandom), sz, 1'($urandom), $urandom_range(0, 2), got);
    end

    bad = 0;
    for (int i = 0; i < NWORDS; i++) if (ram[i] !== ref_word(4 * i)) bad++;
    check("final_ram_image", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
